// File: rtl/pc_pkg.sv
// Shared types and defaults for the fetch-side PC sequencer.
package pc_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_TRAP_VEC = 32'h0000_0100;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_STALL, ST_DRAIN} pc_state_e;
  typedef enum logic [1:0] {SEL_HOLD, SEL_INC, SEL_REDIR, SEL_PEND} pc_sel_e;
endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory request/grant port between the sequencer (master) and imem (slave).
interface pc_sequencer_if;
  logic                    imem_req_o;
  logic [pc_pkg::XLEN-1:0] imem_addr_o;
  logic                    imem_gnt_i;

  modport master (output imem_req_o, imem_addr_o, input  imem_gnt_i);
  modport slave  (input  imem_req_o, imem_addr_o, output imem_gnt_i);
endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC select. With PC_MISALIGN_TRAP_EN, misaligned redirect
// targets are replaced by the trap vector; otherwise they are silently aligned.
module pc_next_sel import pc_pkg::*;
`ifdef PC_MISALIGN_TRAP_EN
#(
  parameter logic [XLEN-1:0] TRAP_VEC = DEF_TRAP_VEC
)
`endif
(
  input  pc_sel_e         sel,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pending,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] redirect_tgt,
  output logic            trap_take,
  output logic [XLEN-1:0] next_pc
);
`ifdef PC_MISALIGN_TRAP_EN
  assign trap_take    = |redirect_pc[1:0];
  assign redirect_tgt = trap_take ? TRAP_VEC : redirect_pc;
`else
  assign trap_take    = 1'b0;
  assign redirect_tgt = redirect_pc & ~XLEN'(INSTR_BYTES - 1);
`endif

  always_comb begin
    case (sel)
      SEL_INC:   next_pc = pc + XLEN'(INSTR_BYTES);
      SEL_REDIR: next_pc = redirect_tgt;
      SEL_PEND:  next_pc = pending;
      default:   next_pc = pc;
    endcase
  end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: owns the PC, runs the imem req/gnt handshake, applies
// stalls and EX redirects. Optional misaligned-target trap: PC_MISALIGN_TRAP_EN.
module pc_sequencer import pc_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
`ifdef PC_MISALIGN_TRAP_EN
  , parameter logic [XLEN-1:0] TRAP_VEC = DEF_TRAP_VEC
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  pc_sequencer_if.master   imem,
  output logic [XLEN-1:0]  pc_o,
  output logic             pc_valid_o,
  output logic             flush_o,
  output logic             trap_o,
  output logic [XLEN-1:0]  trap_epc_o
);
  pc_state_e       state_q, state_d;
  pc_sel_e         sel;
  logic [XLEN-1:0] pc_q, next_pc, pend_q, pend_d, pc_out_d, epc_d, redirect_tgt;
  logic            locked_q, req, fire, lock_hold, trap_take;
  logic            pv_d, flush_d, trap_d;

  // A request left ungranted keeps req/addr pinned, whatever stall or redirect say.
  assign req       = locked_q | (state_q == ST_RUN && !stall_i && !redirect_valid_i);
  assign fire      = req & imem.imem_gnt_i;
  assign lock_hold = req & ~imem.imem_gnt_i;

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = pc_q;

  pc_next_sel
`ifdef PC_MISALIGN_TRAP_EN
  #(.TRAP_VEC(TRAP_VEC))
`endif
  u_next_sel (
    .sel          (sel),
    .pc           (pc_q),
    .pending      (pend_q),
    .redirect_pc  (redirect_pc_i),
    .redirect_tgt (redirect_tgt),
    .trap_take    (trap_take),
    .next_pc      (next_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pend_q     <= '0;
      locked_q   <= 1'b0;
      pc_o       <= '0;
      pc_valid_o <= 1'b0;
      flush_o    <= 1'b0;
      trap_o     <= 1'b0;
      trap_epc_o <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= next_pc;
      pend_q     <= pend_d;
      locked_q   <= lock_hold;
      pc_o       <= pc_out_d;
      pc_valid_o <= pv_d;
      flush_o    <= flush_d;
      trap_o     <= trap_d;
      trap_epc_o <= epc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel      = SEL_HOLD;
    pend_d   = pend_q;
    pc_out_d = pc_o;
    pv_d     = pc_valid_o;
    flush_d  = 1'b0;
    trap_d   = 1'b0;
    epc_d    = trap_epc_o;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (fire) begin
          sel      = SEL_INC;
          pc_out_d = pc_q;
          pv_d     = 1'b1;
          state_d  = stall_i ? ST_STALL : ST_RUN;
        end else if (req) begin
          pv_d = 1'b0;
        end else if (stall_i) begin
          state_d = ST_STALL;
        end
      end
      ST_STALL: if (!stall_i) state_d = ST_RUN;
      // The outstanding fetch is stale: let it complete, then jump to the saved target.
      ST_DRAIN: if (imem.imem_gnt_i) begin
        sel     = SEL_PEND;
        state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase

    if (redirect_valid_i) begin
      flush_d  = 1'b1;
      pv_d     = 1'b0;
      pc_out_d = pc_o;
      trap_d   = trap_take;
      if (trap_take) epc_d = redirect_pc_i;
      if (lock_hold) begin
        pend_d  = redirect_tgt;
        sel     = SEL_HOLD;
        state_d = ST_DRAIN;
      end else begin
        sel     = SEL_REDIR;
        state_d = (state_q == ST_STALL && stall_i) ? ST_STALL : ST_RUN;
      end
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: transaction-level model checked every cycle
// plus hand-computed expectations at key points.
module tb_pc_sequencer;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] pc_o, trap_epc_o;
  logic        pc_valid_o, flush_o, trap_o;

  pc_sequencer_if mif();

  pc_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem             (mif),
    .pc_o             (pc_o),
    .pc_valid_o       (pc_valid_o),
    .flush_o          (flush_o),
    .trap_o           (trap_o),
    .trap_epc_o       (trap_epc_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Model: the fetch stream as a sequence of transactions.
  bit          m_boot, m_hold, m_wait, m_stale;
  logic [31:0] m_pc, m_pend, e_pc, e_epc;
  bit          e_pv, e_flush, e_trap;
  bit          rq, g;

  function automatic logic [31:0] eff_tgt(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
    return (t[1:0] != 2'b00) ? 32'h0000_0100 : t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  function automatic bit exp_req();
    return m_wait || (!m_boot && !m_hold && !stall_i && !redirect_valid_i);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_boot = 1; m_hold = 0; m_wait = 0; m_stale = 0;
      m_pc = 32'h0; m_pend = 32'h0; e_pc = 32'h0; e_epc = 32'h0;
      e_pv = 0; e_flush = 0; e_trap = 0;
    end else begin
      rq = exp_req();
      g  = mif.imem_gnt_i;
      e_flush = 0;
      e_trap  = 0;
      if (redirect_valid_i) begin
        e_flush = 1;
        e_pv    = 0;
`ifdef PC_MISALIGN_TRAP_EN
        if (redirect_pc_i[1:0] != 2'b00) begin e_trap = 1; e_epc = redirect_pc_i; end
`endif
        if (rq && !g) begin
          m_wait = 1; m_stale = 1; m_pend = eff_tgt(redirect_pc_i);
        end else begin
          m_pc = eff_tgt(redirect_pc_i); m_wait = 0; m_stale = 0; m_hold = m_hold && stall_i;
        end
        m_boot = 0;
      end else if (rq && g) begin
        if (m_stale) m_pc = m_pend;
        else begin e_pc = m_pc; e_pv = 1; m_pc = m_pc + 32'd4; m_hold = stall_i; end
        m_wait = 0; m_stale = 0;
      end else if (rq) begin
        m_wait = 1;
        if (!m_stale) e_pv = 0;
      end else if (m_boot) m_boot = 0;
      else if (m_hold) m_hold = stall_i;
      else if (stall_i) m_hold = 1;
    end
  end

  always @(negedge clk) begin
    chk("req",      {31'b0, mif.imem_req_o}, {31'b0, exp_req()});
    chk("addr",     mif.imem_addr_o, m_pc);
    chk("pc_o",     pc_o, e_pc);
    chk("pc_valid", {31'b0, pc_valid_o}, {31'b0, e_pv});
    chk("flush",    {31'b0, flush_o}, {31'b0, e_flush});
    chk("trap",     {31'b0, trap_o}, {31'b0, e_trap});
    chk("trap_epc", trap_epc_o, e_epc);
  end

  task automatic step(input bit s, input bit r, input logic [31:0] rt, input bit gn);
    @(posedge clk); #1;
    stall_i = s; redirect_valid_i = r; redirect_pc_i = rt; mif.imem_gnt_i = gn;
    #2;
  endtask

  initial begin
    mif.imem_gnt_i = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("rst_req",   {31'b0, mif.imem_req_o}, 32'h0);
    chk("rst_addr",  mif.imem_addr_o, 32'h0);
    chk("rst_pv",    {31'b0, pc_valid_o}, 32'h0);
    chk("rst_flush", {31'b0, flush_o}, 32'h0);
    repeat (2) @(posedge clk);
    @(posedge clk); #1 rst = 1'b1; mif.imem_gnt_i = 1'b1; #2;
    chk("boot_noreq", {31'b0, mif.imem_req_o}, 32'h0);
    step(0, 0, 0, 1); chk("first_req", {31'b0, mif.imem_req_o}, 32'h1);
                      chk("first_addr", mif.imem_addr_o, 32'h0);
    step(0, 0, 0, 1); chk("pc0", pc_o, 32'h0); chk("addr4", mif.imem_addr_o, 32'h4);
    step(0, 0, 0, 0); chk("pc4", pc_o, 32'h4); chk("addr8", mif.imem_addr_o, 32'h8);
    step(1, 0, 0, 0); chk("lock_req", {31'b0, mif.imem_req_o}, 32'h1);
                      chk("lock_addr", mif.imem_addr_o, 32'h8);
    step(1, 0, 0, 0); chk("lock_addr2", mif.imem_addr_o, 32'h8);
    step(1, 0, 0, 1); chk("lock_req3", {31'b0, mif.imem_req_o}, 32'h1);
    step(1, 0, 0, 1); chk("stall_noreq", {31'b0, mif.imem_req_o}, 32'h0);
                      chk("pc8_held", pc_o, 32'h8);
    step(0, 0, 0, 1); chk("stall_exit", {31'b0, mif.imem_req_o}, 32'h0);
    step(0, 0, 0, 1); chk("resume_addr", mif.imem_addr_o, 32'hC);
    step(0, 1, 32'h200, 1);
    step(0, 0, 0, 1); chk("flush1", {31'b0, flush_o}, 32'h1);
                      chk("redir_addr", mif.imem_addr_o, 32'h200);
    step(0, 1, 32'h10, 1); chk("flush_off", {31'b0, flush_o}, 32'h0);
                      chk("pc200", pc_o, 32'h200);
    step(0, 0, 0, 0); chk("addr10", mif.imem_addr_o, 32'h10);
    step(0, 1, 32'h300, 0); chk("drain_req", {31'b0, mif.imem_req_o}, 32'h1);
    step(0, 1, 32'h400, 0); chk("drain_addr", mif.imem_addr_o, 32'h10);
    step(0, 0, 0, 1); chk("flush2", {31'b0, flush_o}, 32'h1);
    step(0, 0, 0, 1); chk("stale_drop", {31'b0, pc_valid_o}, 32'h0);
                      chk("pend_addr", mif.imem_addr_o, 32'h400);
    step(0, 1, 32'hFFFF_FFFC, 1); chk("pc400", pc_o, 32'h400);
    step(0, 0, 0, 1); chk("top_addr", mif.imem_addr_o, 32'hFFFF_FFFC);
    step(0, 1, 32'h102, 1); chk("wrap_addr", mif.imem_addr_o, 32'h0);
                      chk("pc_top", pc_o, 32'hFFFF_FFFC);
    step(0, 0, 0, 1); chk("mis_addr", mif.imem_addr_o, 32'h100);
`ifdef PC_MISALIGN_TRAP_EN
    chk("trap_on", {31'b0, trap_o}, 32'h1); chk("epc_on", trap_epc_o, 32'h102);
`else
    chk("trap_off", {31'b0, trap_o}, 32'h0); chk("epc_off", trap_epc_o, 32'h0);
`endif
    step(0, 0, 0, 0);
    step(0, 1, 32'h500, 0);
    step(0, 0, 0, 0);
    rst = 1'b0; #1;
    chk("async_req", {31'b0, mif.imem_req_o}, 32'h0);
    chk("async_addr", mif.imem_addr_o, 32'h0);
    chk("async_pc", pc_o, 32'h0);
    chk("async_flush", {31'b0, flush_o}, 32'h0);
    @(posedge clk); #1 rst = 1'b1; mif.imem_gnt_i = 1'b1; #2;
    step(0, 0, 0, 1); chk("rst_no_pend", mif.imem_addr_o, 32'h0);
    step(0, 0, 0, 1); chk("rst_addr4", mif.imem_addr_o, 32'h4);

    for (int i = 0; i < 300; i++)
      step(($urandom % 4) == 0, ($urandom % 6) == 0, $urandom, ($urandom % 3) != 0);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller that owns the program counter and sequences instruction fetch for the pipelined RISC-V core. It chooses each next PC (sequential +4, EX-stage redirect, optional trap vector), runs a request/grant handshake with instruction memory, and honours hazard-unit stalls. It emits the fetched PC plus a one-cycle flush pulse toward IF/ID. It sits between the hazard unit, the EX-stage branch resolver and the instruction memory port.

## Interface
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- TRAP_VEC, 32'h0000_0100, target on misaligned redirect (only with PC_MISALIGN_TRAP_EN).

- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_i  in  1  hazard-unit hold; no new fetch, outputs frozen.
- redirect_valid_i  in  1  EX-stage taken branch/jump.
- redirect_pc_i  in  XLEN  redirect target.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  XLEN  fetch address.
- imem_gnt_i  in  1  memory accepted request this cycle.
- pc_o  out  XLEN  PC of last granted fetch.
- pc_valid_o  out  1  pc_o is live for IF/ID.
- flush_o  out  1  one-cycle pulse: kill IF/ID contents.
- trap_o  out  1  misaligned-target trap pulse (macro only).
- trap_epc_o  out  XLEN  offending target (macro only).

## Operation
- States: BOOT, RUN, STALL, DRAIN.
- Reset: pc=RESET_PC, state BOOT, imem_req_o=0, imem_addr_o=RESET_PC, pc_o=0, pc_valid_o=0, flush_o=0, trap_o=0, trap_epc_o=0, pending empty.
- BOOT -> RUN unconditionally after one cycle; no request in BOOT.
- RUN: imem_req_o=1, imem_addr_o=pc. On grant: pc <= pc+4 (mod 2^XLEN, wraps to 0), pc_o <= granted address, pc_valid_o <= 1. No grant: pc_valid_o <= 0; address held.
- Lock rule: once imem_req_o=1 without grant, req and addr hold stable until granted, regardless of stall or redirect.
- stall_i=1 and not locked: RUN -> STALL; req=0; pc, pc_o, pc_valid_o frozen. stall_i=1 while locked: stay RUN until grant, then STALL with the granted pc_o/pc_valid_o held. STALL -> RUN when stall_i=0.
- Redirect (priority over stall): flush_o=1 next cycle; pc_valid_o <= 0. Not locked: pc <= target, state RUN. Locked: target saved in pending, state DRAIN; the stale grant is discarded (pc_valid_o stays 0), then pc <= pending, RUN.
- Redirect while DRAIN or a second redirect pending: overwrite pending (last wins), flush_o pulses again.
- Redirect during STALL: pc <= target, flush_o pulse, state stays STALL until stall_i=0.
- Grant while imem_req_o=0 is ignored.

## Timing
- Request to pc_valid_o: one cycle after the grant edge.
- Redirect sampled at edge N: flush_o high N+1 only; first fetch of target requested in cycle N+1 (unlocked) or the cycle after stale grant (DRAIN).
- Sustained throughput: one fetch per cycle with gnt held high.
- Reset asserted mid-operation: all outputs return to reset values immediately (async); pending cleared.

## Configuration
- PC_MISALIGN_TRAP_EN defined: redirect target with [1:0]!=0 uses TRAP_VEC instead; trap_o pulses with flush_o and trap_epc_o = raw target.
- Undefined: target[1:0] forced to 0 silently; trap_o and trap_epc_o tied 0.

## Structure
- pc_pkg: state enum, XLEN, INSTR_BYTES=4, RESET_PC/TRAP_VEC defaults.
- Sub-module pc_next_sel: combinational next-PC select (hold, +4, redirect, pending, trap vector).

## Test plan
- Reset release, gnt=1 always -> req rises cycle 2 at 0x0; pc_o 0x0, 0x4, 0x8 on consecutive cycles.
- gnt low 3 cycles with stall_i pulsed -> addr 0x8 stable and req held until grant, then STALL.
- Redirect to 0x200 unlocked -> flush_o one cycle, next req addr 0x200, no 0x10 reported.
- Redirect to 0x300 while locked on 0x10, then redirect to 0x400 before grant -> 0x10 grant dropped, next fetch 0x400, two flush pulses.
- pc=0xFFFF_FFFC granted -> next addr 0x0000_0000.
- Redirect to 0x102 -> macro on: fetch 0x100 (TRAP_VEC), trap_epc_o 0x102; off: fetch 0x100, trap_o 0.
